pc_sequencer: RTL

- Next-PC controller that sequences the 12-bit program counter each cycle.
- Selects between increment, branch/jump redirect, call/return via a small return-address stack (RAS), interrupt entry/exit, stall and halt.
- Sits between the instruction decoder (control inputs) and the fetch path (pc_current drives instruction memory).
- Owns the PC register and the next-PC adder internally.

---
 rtl/pc_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch PC, a circular return-address stack and
// interrupt entry/exit sequencing; pc_current is registered, pc_valid follows state.
module pc_sequencer #(
    parameter int              PC_W      = 12,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_VEC = 12'h000,
    parameter logic [PC_W-1:0] IRQ_VEC   = 12'hFF0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            call,
    input  logic            ret,
    input  logic            iret,
    input  logic            irq,
    output logic [PC_W-1:0] pc_current,
    output logic            pc_valid,
    output logic            irq_ack,
    output logic            ras_overflow,
    output logic            ras_underflow,
    output logic [1:0]      state
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_IRQ    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [CNT_W-1:0] ras_cnt;
    logic [PC_W-1:0]  epc;
    logic             irq_en;

    logic [PC_W-1:0]  pc_inc;
    logic [PTR_W-1:0] ras_top;
    logic             ras_empty;
    logic             ras_full;
    logic             take_irq;

    assign pc_inc    = pc_current + PC_W'(1);
    assign ras_top   = ras_ptr - PTR_W'(1);
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
    assign pc_valid  = (state == ST_RUN);

    // Interrupts are accepted from an unstalled RUN cycle or from HALTED.
    assign take_irq = irq && irq_en &&
                      (((state == ST_RUN) && !stall) || (state == ST_HALTED));

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_current    <= RESET_VEC;
            state         <= ST_RUN;
            irq_ack       <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            ras_ptr       <= '0;
            ras_cnt       <= '0;
            epc           <= '0;
            irq_en        <= 1'b1;
        end else begin
            irq_ack <= take_irq;
            if (take_irq) begin
                epc        <= pc_current;
                pc_current <= IRQ_VEC;
                irq_en     <= 1'b0;
                state      <= ST_IRQ;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (!stall) begin
                            if (halt) begin
                                state <= ST_HALTED;
                            end else if (iret) begin
                                pc_current <= epc;
                                irq_en     <= 1'b1;
                            end else if (ret) begin
                                if (ras_empty) begin
                                    pc_current    <= pc_inc;
                                    ras_underflow <= 1'b1;
                                end else begin
                                    pc_current <= ras_mem[ras_top];
                                    ras_ptr    <= ras_top;
                                    ras_cnt    <= ras_cnt - CNT_W'(1);
                                end
                            end else if (call) begin
                                // When full, the write slot is the oldest entry.
                                ras_mem[ras_ptr] <= pc_inc;
                                ras_ptr          <= ras_ptr + PTR_W'(1);
                                pc_current       <= branch_target;
                                if (ras_full) begin
                                    ras_overflow <= 1'b1;
                                end else begin
                                    ras_cnt <= ras_cnt + CNT_W'(1);
                                end
                            end else if (branch_taken) begin
                                pc_current <= branch_target;
                            end else begin
                                pc_current <= pc_inc;
                            end
                        end
                    end
                    ST_IRQ:    state <= ST_RUN;
                    ST_HALTED: state <= ST_HALTED;
                    default:   state <= ST_RUN;
                endcase
            end
        end
    end

endmodule
